dma_desc_sequencer: RTL



---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_desc_fifo.sv | 64 ++++++
 rtl/dma_desc_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types plus the descriptor-sequencer state encoding and default queue depth.
package dma_pkg;

    localparam int unsigned DMA_DESC_DEPTH = 4;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic active;
        logic done;
    } s_dma_status_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } s_dma_error_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        HALT
    } e_dma_seq_state_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// Register-based descriptor queue with a combinationally visible head and a synchronous flush.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = DMA_DESC_DEPTH,
    parameter type         T     = s_dma_desc_t
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  T                         din,
    input  logic                     pop,
    input  logic                     flush,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    // A flush wins over everything, so a push in the flush cycle is lost as well.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dma_desc_sequencer.sv
// Queues descriptors and launches them one at a time into the DMA; tracks completion,
// halts on error and keeps sticky overflow / error / interrupt status.
module dma_desc_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned DESC_DEPTH = DMA_DESC_DEPTH,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          desc_push_i,
    input  s_dma_desc_t                   desc_i,
    output logic                          desc_full_o,
    output logic [$clog2(DESC_DEPTH):0]   desc_level_o,
    input  logic                          abort_i,
    input  logic                          irq_clear_i,
    output logic                          dma_go_o,
    output s_dma_desc_t                   dma_desc_o,
    input  s_dma_status_t                 dma_stats_i,
    input  s_dma_error_t                  dma_error_i,
    output logic                          busy_o,
    output logic [CNT_W-1:0]              done_cnt_o,
    output s_dma_error_t                  err_latched_o,
    output logic                          overflow_o,
    output logic                          irq_o
);

    e_dma_seq_state_t state_q, state_d;
    s_dma_desc_t      desc_q, desc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    s_dma_error_t     err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             irq_q, irq_d;
    logic             done_prev_q;
    logic             err_prev_q;
    logic             done_rise;
    logic             err_rise;
    logic             queue_empty_next;

    logic             fifo_pop;
    s_dma_desc_t      fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_active;

    assign unused_active = dma_stats_i.active;

    dma_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .T     (s_dma_desc_t)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (desc_push_i),
        .din   (desc_i),
        .pop   (fifo_pop),
        .flush (abort_i),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (desc_level_o)
    );

    assign done_rise = dma_stats_i.done && !done_prev_q;
    assign err_rise  = dma_error_i.valid && !err_prev_q;

    // No pop happens in RUN, so the queue is empty afterwards unless something is pushed or
    // the queue is being flushed.
    assign queue_empty_next = abort_i || (fifo_empty && !desc_push_i);

    // Next-state, launch, completion and sticky-status logic.
    always_comb begin
        state_d  = state_q;
        desc_d   = desc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        irq_d    = irq_q;
        fifo_pop = 1'b0;

        // Clears first so that any set event below overrides them.
        if (irq_clear_i) begin
            irq_d = 1'b0;
            err_d = '0;
            ovf_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_head.num_bytes != '0) begin
                        desc_d  = fifo_head;
                        state_d = LAUNCH;
                    end else begin
                        // Zero-length descriptors complete trivially without touching the DMA.
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (err_rise) begin
                    if (irq_clear_i || !err_q.valid) err_d = dma_error_i;
                    irq_d   = 1'b1;
                    state_d = HALT;
                end else if (done_rise) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                    if (queue_empty_next) irq_d = 1'b1;
                end
            end
            HALT: begin
                if (irq_clear_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (desc_push_i && fifo_full) begin
            ovf_d = 1'b1;
            irq_d = 1'b1;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            desc_q      <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            done_prev_q <= 1'b0;
            err_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            desc_q      <= desc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            done_prev_q <= dma_stats_i.done;
            err_prev_q  <= dma_error_i.valid;
        end
    end

    assign dma_go_o      = (state_q == LAUNCH);
    assign dma_desc_o    = desc_q;
    assign busy_o        = (state_q != IDLE) || !fifo_empty;
    assign desc_full_o   = fifo_full;
    assign done_cnt_o    = cnt_q;
    assign err_latched_o = err_q;
    assign overflow_o    = ovf_q;
    assign irq_o         = irq_q;

endmodule
